adder_sum_accumulator: RTL and testbench

- Downstream consumer of the 4-bit pipelined adder's {co,s} result stream.
- Tracks which adder outputs are valid through a delay line matched to the adder's 4-cycle latency.
- Accumulates valid results into a wide frame sum and closes the frame on a "last" tag.
- Hands completed frames to a consumer through a 2-entry valid/ready output buffer.

---
 rtl/adder_pipe_pkg.sv | 16 +
 rtl/acc_out_fifo.sv | 64 ++++++
 rtl/adder_sum_accumulator.sv | 120 ++++++++++++
 tb/tb_adder_sum_accumulator.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
// Shared constants for the 4-bit pipelined adder and its sum accumulator:
// adder latency/result width and the frame-record field widths.
package adder_pipe_pkg;

  localparam int ADD_LAT_DEF = 4;
  localparam int ADD_RES_W   = 5;
  localparam int ACC_W_DEF   = 12;
  localparam int CNT_W_DEF   = 8;
  localparam int REC_OVF_W   = 1;

  // Frame record layout, MSB first: {sum, count, ovf}.
  function automatic int rec_w(input int acc_w, input int cnt_w);
    return acc_w + cnt_w + REC_OVF_W;
  endfunction

endpackage

// File: rtl/acc_out_fifo.sv
// Two-entry synchronous FIFO for completed frame records. A push into a full
// buffer is accepted only when the head is popped in the same cycle.
module acc_out_fifo
  import adder_pipe_pkg::*;
#(
  parameter int W = rec_w(ACC_W_DEF, CNT_W_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic         drop
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic [1:0]   cnt_q, cnt_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic         empty, full, pop, push_ok;

  assign head_valid = (cnt_q != 2'd0);
  assign head_data  = mem_q[rd_q];

  always_comb begin
    empty   = (cnt_q == 2'd0);
    full    = (cnt_q == 2'd2);
    pop     = pop_ready & ~empty;
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;

    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (push_ok) begin
      mem_d[wr_q] = push_data;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    cnt_d = cnt_q + 2'(push_ok) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      cnt_q <= '0;
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
    end
  end

endmodule

// File: rtl/adder_sum_accumulator.sv
// Accumulates the pipelined adder's {co,s} stream into per-frame sums and
// queues completed frames. Optional macro ACC_SATURATE_EN clamps sums on carry.
module adder_sum_accumulator
  import adder_pipe_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_last,
  input  logic [3:0]       add_s,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             drop_err,
  output logic             busy
);

  localparam int RW = rec_w(ACC_W, CNT_W);

  logic [ADD_LAT-1:0] dl_valid_q, dl_valid_d;
  logic [ADD_LAT-1:0] dl_last_q, dl_last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               drop_err_q, drop_err_d;

  logic               d_valid, d_last;
  logic [ACC_W-1:0]   v;
  logic [ACC_W:0]     sum_w;
  logic               carry;
  logic [ACC_W-1:0]   acc_new;
  logic [CNT_W-1:0]   cnt_new;
  logic               ovf_new;
  logic               push;
  logic [RW-1:0]      push_rec;
  logic [RW-1:0]      head_rec;
  logic               fifo_drop;

  always_comb begin
    // Shift left so the oldest issue sits at the top bit, aligned with {co,s}.
    dl_valid_d = (dl_valid_q << 1) | ADD_LAT'(issue_valid);
    dl_last_d  = (dl_last_q << 1) | ADD_LAT'(issue_valid & issue_last);
    d_valid    = dl_valid_q[ADD_LAT-1];
    d_last     = dl_last_q[ADD_LAT-1];

    v     = ACC_W'({add_co, add_s});
    sum_w = {1'b0, acc_q} + {1'b0, v};
    carry = sum_w[ACC_W];
`ifdef ACC_SATURATE_EN
    acc_new = carry ? '1 : sum_w[ACC_W-1:0];
`else
    acc_new = sum_w[ACC_W-1:0];
`endif
    cnt_new  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    ovf_new  = ovf_q | carry;
    push_rec = {acc_new, cnt_new, ovf_new};

    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    push  = 1'b0;
    if (d_valid) begin
      if (d_last) begin
        push  = 1'b1;
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_new;
        cnt_d = cnt_new;
        ovf_d = ovf_new;
      end
    end

    drop_err_d = drop_err_q | fifo_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid_q <= '0;
      dl_last_q  <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      dl_valid_q <= dl_valid_d;
      dl_last_q  <= dl_last_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      drop_err_q <= drop_err_d;
    end
  end

  acc_out_fifo #(
    .W (RW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop_ready (out_ready),
    .head_valid(out_valid),
    .head_data (head_rec),
    .drop      (fifo_drop)
  );

  assign {out_sum, out_count, out_ovf} = head_rec;
  assign drop_err = drop_err_q;
  assign busy     = (|dl_valid_q) | (cnt_q != '0) | (acc_q != '0);

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: a default-width instance and a
// 5-bit accumulator instance share one stimulus stream and an adder model.
module tb_adder_sum_accumulator;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_last;
  logic [4:0]  iss_val;
  logic        out_ready;
  logic [4:0]  pipe [LAT];
  logic [3:0]  add_s;
  logic        add_co;

  logic        o_valid, o_ovf, o_drop, o_busy;
  logic [11:0] o_sum;
  logic [7:0]  o_cnt;
  logic        o5_valid, o5_ovf, o5_drop, o5_busy;
  logic [4:0]  o5_sum;
  logic [7:0]  o5_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Adder model: the operand value emerges LAT cycles after issue.
  always @(posedge clk) begin
    pipe[0] <= issue_valid ? iss_val : 5'd0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {add_co, add_s} = pipe[LAT-1];

  adder_sum_accumulator #(.ACC_W(12), .CNT_W(8), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
    .add_s(add_s), .add_co(add_co), .out_valid(o_valid), .out_ready(out_ready),
    .out_sum(o_sum), .out_count(o_cnt), .out_ovf(o_ovf), .drop_err(o_drop), .busy(o_busy)
  );

  adder_sum_accumulator #(.ACC_W(5), .CNT_W(8), .ADD_LAT(LAT)) dut5 (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_last(issue_last),
    .add_s(add_s), .add_co(add_co), .out_valid(o5_valid), .out_ready(out_ready),
    .out_sum(o5_sum), .out_count(o5_cnt), .out_ovf(o5_ovf), .drop_err(o5_drop), .busy(o5_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    iss_val     = 5'd0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input logic [4:0] val, input logic last);
    issue_valid = 1'b1;
    issue_last  = last;
    iss_val     = val;
    step();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
  endtask

  task automatic do_reset();
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    iss_val     = 5'd0;
    out_ready   = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({o_valid, o_sum, o_cnt, o_ovf, o_drop, o_busy} !== 24'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b sum=%0d cnt=%0d ovf=%b drop=%b busy=%b, expected all 0",
               o_valid, o_sum, o_cnt, o_ovf, o_drop, o_busy);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    issue(5'd15, 1'b0);
    issue(5'd31, 1'b0);
    issue(5'd7, 1'b1);
    idle(3);
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: out_valid=%b expected 0", o_valid);
    end
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: busy=%b expected 1", o_busy);
    end
    idle(1);
    checks++;
    if ({o_valid, o_sum, o_cnt, o_ovf} !== {1'b1, 12'd53, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL single_frame: got v=%b sum=%0d cnt=%0d ovf=%b expected v=1 sum=53 cnt=3 ovf=0",
               o_valid, o_sum, o_cnt, o_ovf);
    end
    idle(2);
    checks++;
    if ({o_valid, o_sum} !== {1'b1, 12'd53}) begin
      errors++;
      $display("FAIL single_hold: got v=%b sum=%0d expected v=1 sum=53", o_valid, o_sum);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({o_valid, o_busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_pop: got v=%b busy=%b expected 0 0", o_valid, o_busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(5'd10, 1'b0);
    issue(5'd20, 1'b1);
    issue(5'd5, 1'b1);
    idle(6);
    checks++;
    if ({o_valid, o_sum, o_cnt} !== {1'b1, 12'd30, 8'd2}) begin
      errors++;
      $display("FAIL b2b_first: got v=%b sum=%0d cnt=%0d expected v=1 sum=30 cnt=2", o_valid, o_sum, o_cnt);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({o_valid, o_sum, o_cnt} !== {1'b1, 12'd5, 8'd1}) begin
      errors++;
      $display("FAIL b2b_second: got v=%b sum=%0d cnt=%0d expected v=1 sum=5 cnt=1", o_valid, o_sum, o_cnt);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: out_valid=%b expected 0", o_valid);
    end
  endtask

  task automatic test_last_without_valid();
    do_reset();
    issue(5'd3, 1'b0);
    issue_last = 1'b1;
    step();
    issue_last = 1'b0;
    issue(5'd4, 1'b1);
    idle(6);
    checks++;
    if ({o_valid, o_sum, o_cnt} !== {1'b1, 12'd7, 8'd2}) begin
      errors++;
      $display("FAIL last_no_valid: got v=%b sum=%0d cnt=%0d expected v=1 sum=7 cnt=2", o_valid, o_sum, o_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [4:0] exp5;
    do_reset();
`ifdef ACC_SATURATE_EN
    exp5 = 5'd31;
`else
    exp5 = 5'd0;
`endif
    issue(5'd31, 1'b0);
    issue(5'd1, 1'b1);
    idle(5);
    checks++;
    if ({o5_valid, o5_sum, o5_cnt, o5_ovf} !== {1'b1, exp5, 8'd2, 1'b1}) begin
      errors++;
      $display("FAIL ovf_narrow: got v=%b sum=%0d cnt=%0d ovf=%b expected v=1 sum=%0d cnt=2 ovf=1",
               o5_valid, o5_sum, o5_cnt, o5_ovf, exp5);
    end
    checks++;
    if ({o_valid, o_sum, o_ovf} !== {1'b1, 12'd32, 1'b0}) begin
      errors++;
      $display("FAIL ovf_wide: got v=%b sum=%0d ovf=%b expected v=1 sum=32 ovf=0", o_valid, o_sum, o_ovf);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    issue(5'd1, 1'b1);
    issue(5'd2, 1'b1);
    issue(5'd3, 1'b1);
    idle(6);
    checks++;
    if ({o_valid, o_sum, o_drop} !== {1'b1, 12'd1, 1'b1}) begin
      errors++;
      $display("FAIL bp_full: got v=%b sum=%0d drop=%b expected v=1 sum=1 drop=1", o_valid, o_sum, o_drop);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({o_valid, o_sum} !== {1'b1, 12'd2}) begin
      errors++;
      $display("FAIL bp_second: got v=%b sum=%0d expected v=1 sum=2", o_valid, o_sum);
    end
    step();
    checks++;
    if ({o_valid, o_drop} !== 2'b01) begin
      errors++;
      $display("FAIL bp_drained: got v=%b drop=%b expected v=0 drop=1", o_valid, o_drop);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop_push();
    do_reset();
    issue(5'd4, 1'b1);
    issue(5'd5, 1'b1);
    issue(5'd6, 1'b1);
    idle(3);
    checks++;
    if ({o_valid, o_sum} !== {1'b1, 12'd4}) begin
      errors++;
      $display("FAIL fpp_full: got v=%b sum=%0d expected v=1 sum=4", o_valid, o_sum);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if ({o_valid, o_sum, o_drop} !== {1'b1, 12'd5, 1'b0}) begin
      errors++;
      $display("FAIL fpp_after: got v=%b sum=%0d drop=%b expected v=1 sum=5 drop=0", o_valid, o_sum, o_drop);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if ({o_valid, o_sum} !== {1'b1, 12'd6}) begin
      errors++;
      $display("FAIL fpp_order: got v=%b sum=%0d expected v=1 sum=6", o_valid, o_sum);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if ({o_valid, o_drop} !== 2'b00) begin
      errors++;
      $display("FAIL fpp_end: got v=%b drop=%b expected 0 0", o_valid, o_drop);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    do_reset();
    issue(5'd9, 1'b1);
    idle(1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({o_busy, o_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_busy: got busy=%b v=%b expected 0 0", o_busy, o_valid);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (o_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_mid_output: out_valid high on %0d cycles, expected 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_last  = 1'b0;
    iss_val     = 5'd0;
    out_ready   = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_last_without_valid();
    test_overflow();
    test_backpressure();
    test_full_pop_push();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
